lnrv_exu_alu: RTL and testbench
===============================

Name: lnrv_exu_alu

Overview:
- Shared integer ALU of the EXU; consumes the single arbitrated request from the ALU request mux (regular, branch, CSR and LSU clients).
- Computes the operation, then holds the result in a one-entry output register with a valid/ready handshake back to the requesting EXU unit.
- Single-issue pipeline: at most one operation in flight.
- Optional area-reduced build replaces the barrel shifter with a 1-bit/cycle serial shifter.

Parameters:
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- flush  input  1  pipeline flush; discards in-flight and buffered work
- alu_op_vld  input  1  request valid
- alu_op_rdy  output  1  request accepted when vld & rdy
- alu_op_bus  input  `ALU_OP_BUS_WIDTH  one-hot operation select
- alu_in1  input  32  operand 1
- alu_in2  input  32  operand 2 (shift amount = alu_in2[4:0])
- alu_res_vld  output  1  result valid
- alu_res_rdy  input  1  consumer takes result when vld & rdy
- alu_res  output  32  result

Behaviour:
- Single clock, clk; reset rst is synchronous, active-high.
- On reset: alu_res_vld=0, alu_res=0, FSM=IDLE, shift counter=0.
- Op bus is one-hot, bit indices per `ALU_OP_* in lnrv_def.v: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, PASS2 (in2), EQ, NE, GE, GEU.
- Compare ops (SLT, SLTU, EQ, NE, GE, GEU) return 32'h0/32'h1; SLT and GE are signed.
- All arithmetic is modulo 2^32; no flags.
- Result select is an AND-OR mux: all-zero bus gives 0; multi-hot is illegal and gives the OR of the selected results.
- Base mode is fully pipelined, latency 1:
  - alu_op_rdy = !flush & (!alu_res_vld | alu_res_rdy).
  - On accept, the result register loads and alu_res_vld=1 next cycle.
- Result register:
  - Holds alu_res stable while vld & !rdy.
  - Pop and accept in the same cycle reloads it; vld stays 1, giving back-to-back throughput of 1/cycle.
  - Pop with no accept clears vld; alu_res keeps its last value.
- flush:
  - Next cycle alu_res_vld=0 and FSM=IDLE.
  - Nothing is accepted in a flush cycle.
  - flush has priority over both pop and accept.
- rst has priority over flush.

Optional Feature:
- Macro: LNRV_ALU_SERIAL_SHIFT_EN.
- Undefined: SLL/SRL/SRA use a combinational barrel shifter with latency 1, like every other op.
- Defined: shifts are iterative, with FSM states IDLE and SHIFT.
  - A shift with shamt==0 completes like a normal op: result = in1 at cycle +1.
  - Otherwise, accept in IDLE loads the work register with in1, loads the counter with shamt, and moves to SHIFT.
  - Each SHIFT cycle shifts 1 bit (SRA replicates bit 31) and decrements the counter.
  - When the counter is 1, the shifted value is written to the result register and the FSM returns to IDLE.
  - Result is valid at cycle shamt+1 after accept; latency range 1..32.
  - alu_op_rdy = 0 while in SHIFT.
  - A shift is accepted only when the result register is empty or being popped, so it is empty at write time.
  - flush or rst mid-shift aborts: FSM=IDLE and no result is produced.
  - Non-shift ops are unchanged.

Decomposition:
- lnrv_def.v holds `ALU_OP_BUS_WIDTH (15) and the `ALU_OP_* bit indices.
- Sub-module lnrv_exu_alu_serial_shifter (work register, counter, FSM) is instantiated only under LNRV_ALU_SERIAL_SHIFT_EN.
- Base datapath stays in the top.

Test Plan:
- Reset, then ADD with in1=32'hFFFF_FFFF, in2=1 and res_rdy=1 -> alu_res=0 and res_vld=1 one cycle after accept.
- SLT with in1=32'hFFFF_FFFF, in2=0 -> 1; SLTU with the same operands -> 0; GEU with in1=5, in2=5 -> 1.
- res_rdy=0 for 3 cycles after XOR result 32'hA5A5_0000 -> res stays stable and op_rdy=0; then a pop and a new OR in the same cycle -> res_vld stays 1 with the new value.
- flush while res_vld=1 and a new request is pending -> res_vld=0 next cycle and the request is not accepted.
- Serial build, SRA with in1=32'h8000_0000, shamt=4 -> op_rdy=0 for 4 cycles; result 32'hF800_0000 valid at cycle 5.
- Serial build, SLL with shamt=0 -> in1 returned at cycle 1; flush at cycle 2 of a shamt=8 shift -> no result and op_rdy=1 next cycle.

Source files
------------

// File: rtl/lnrv_exu_alu_pkg.sv
// -----------------------------------------------------------------------------
// lnrv_exu_alu_pkg
//   Shared definitions for the EXU integer ALU.
//   - Op-bus macros (`ALU_OP_BUS_WIDTH and the `ALU_OP_* bit indices). These are
//     the lnrv_def.v contents, kept here so they are defined before any ALU
//     file that uses them.
//   - Serial-shifter FSM state and shift-mode enums, plus a one-bit shift helper.
//   Used with the optional serial shifter build (macro LNRV_ALU_SERIAL_SHIFT_EN).
// -----------------------------------------------------------------------------
`ifndef LNRV_DEF_V
`define LNRV_DEF_V
`define ALU_OP_BUS_WIDTH 15
`define ALU_OP_ADD   0
`define ALU_OP_SUB   1
`define ALU_OP_SLT   2
`define ALU_OP_SLTU  3
`define ALU_OP_XOR   4
`define ALU_OP_OR    5
`define ALU_OP_AND   6
`define ALU_OP_SLL   7
`define ALU_OP_SRL   8
`define ALU_OP_SRA   9
`define ALU_OP_PASS2 10
`define ALU_OP_EQ    11
`define ALU_OP_NE    12
`define ALU_OP_GE    13
`define ALU_OP_GEU   14
`endif

package lnrv_exu_alu_pkg;

  localparam int ALU_XLEN = 32;

  // Serial shifter FSM states.
  typedef enum logic {
    SH_IDLE  = 1'b0,
    SH_SHIFT = 1'b1
  } shift_state_e;

  // Shift direction / fill captured at accept time.
  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

  // One bit of shift in the selected direction; SRA replicates bit 31.
  function automatic logic [ALU_XLEN-1:0] shift_one(input logic [ALU_XLEN-1:0] v,
                                                    input shift_mode_e m);
    logic [ALU_XLEN-1:0] r;
    case (m)
      SH_LL:   r = {v[ALU_XLEN-2:0], 1'b0};
      SH_RL:   r = {1'b0, v[ALU_XLEN-1:1]};
      SH_RA:   r = {v[ALU_XLEN-1], v[ALU_XLEN-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lnrv_exu_alu_serial_shifter.sv
// -----------------------------------------------------------------------------
// lnrv_exu_alu_serial_shifter
//   Iterative 1-bit/cycle shifter used when LNRV_ALU_SERIAL_SHIFT_EN is defined.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     flush       : abort any shift in progress (back to IDLE, no result)
//     start_i     : load in1/shamt/mode and enter SHIFT (shamt must be non-zero)
//     mode_i      : shift direction/fill
//     in1_i       : value to shift
//     shamt_i     : shift amount (1..31)
//     state_o     : current FSM state (SHIFT means busy)
//     done_o      : final shift cycle; res_o is the finished value this cycle
//     res_o       : shifted value to write into the result register
// -----------------------------------------------------------------------------
module lnrv_exu_alu_serial_shifter
  import lnrv_exu_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start_i,
  input  shift_mode_e         mode_i,
  input  logic [ALU_XLEN-1:0] in1_i,
  input  logic [4:0]          shamt_i,
  output shift_state_e        state_o,
  output logic                done_o,
  output logic [ALU_XLEN-1:0] res_o
);

  shift_state_e        state_q, state_d;
  shift_mode_e         mode_q, mode_d;
  logic [ALU_XLEN-1:0] work_q, work_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ALU_XLEN-1:0] shifted;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    shifted = shift_one(work_q, mode_q);
    res_o   = shifted;
    case (state_q)
      SH_IDLE: begin
        if (start_i) begin
          work_d  = in1_i;
          cnt_d   = shamt_i;
          mode_d  = mode_i;
          state_d = SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 5'd1;
        // Counter at 1 means this cycle's shift is the last one.
        if (cnt_q == 5'd1) begin
          done_o  = 1'b1;
          state_d = SH_IDLE;
        end
      end
      default: state_d = SH_IDLE;
    endcase
    if (flush) begin
      state_d = SH_IDLE;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SH_IDLE;
      mode_q  <= SH_LL;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lnrv_exu_alu.sv
// -----------------------------------------------------------------------------
// lnrv_exu_alu
//   Shared integer ALU of the EXU. Computes one operation per accepted request
//   and holds the result in a one-entry output register.
//   Handshake: a transfer happens on a port in any cycle where its vld and rdy
//   are both 1; vld never depends on rdy, and a held result stays stable until
//   it is taken.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (priority over flush)
//     flush        : drop buffered result / in-flight shift, accept nothing
//     alu_op_vld/rdy, alu_op_bus (one-hot), alu_in1, alu_in2 : request
//     alu_res_vld/rdy, alu_res                              : result
//   Build option: LNRV_ALU_SERIAL_SHIFT_EN replaces the barrel shifter with the
//   lnrv_exu_alu_serial_shifter (1 bit per cycle, latency shamt+1).
// -----------------------------------------------------------------------------
module lnrv_exu_alu
  import lnrv_exu_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alu_op_vld,
  output logic                         alu_op_rdy,
  input  logic [`ALU_OP_BUS_WIDTH-1:0] alu_op_bus,
  input  logic [XLEN-1:0]              alu_in1,
  input  logic [XLEN-1:0]              alu_in2,
  output logic                         alu_res_vld,
  input  logic                         alu_res_rdy,
  output logic [XLEN-1:0]              alu_res
);

  logic [4:0]      shamt;
  logic            slt, sltu, eq;
  logic [XLEN-1:0] sll_r, srl_r, sra_r;
  logic [XLEN-1:0] op_res;

  logic            res_vld_q, res_vld_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            op_acc, pop;
  logic            long_shift, shift_busy, shift_done;
  logic [XLEN-1:0] shift_res;

  assign shamt = alu_in2[4:0];
  assign slt   = $signed(alu_in1) < $signed(alu_in2);
  assign sltu  = alu_in1 < alu_in2;
  assign eq    = alu_in1 == alu_in2;

`ifdef LNRV_ALU_SERIAL_SHIFT_EN
  shift_state_e shift_state;
  shift_mode_e  shift_mode;
  logic         is_shift;

  assign is_shift   = alu_op_bus[`ALU_OP_SLL] | alu_op_bus[`ALU_OP_SRL] |
                      alu_op_bus[`ALU_OP_SRA];
  // shamt==0 shifts complete through the normal latency-1 path.
  assign long_shift = is_shift & (shamt != 5'd0);
  assign shift_mode = alu_op_bus[`ALU_OP_SRA] ? SH_RA :
                      alu_op_bus[`ALU_OP_SRL] ? SH_RL : SH_LL;
  // Zero-amount shift result is the operand itself.
  assign sll_r = alu_in1;
  assign srl_r = alu_in1;
  assign sra_r = alu_in1;

  lnrv_exu_alu_serial_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start_i (op_acc & long_shift),
    .mode_i  (shift_mode),
    .in1_i   (alu_in1),
    .shamt_i (shamt),
    .state_o (shift_state),
    .done_o  (shift_done),
    .res_o   (shift_res)
  );

  assign shift_busy = (shift_state == SH_SHIFT);
`else
  assign sll_r      = alu_in1 << shamt;
  assign srl_r      = alu_in1 >> shamt;
  assign sra_r      = XLEN'($signed(alu_in1) >>> shamt);
  assign long_shift = 1'b0;
  assign shift_busy = 1'b0;
  assign shift_done = 1'b0;
  assign shift_res  = '0;
`endif

  // AND-OR result select: no bit set gives 0, multi-hot ORs the results.
  always_comb begin
    op_res = '0;
    op_res |= {XLEN{alu_op_bus[`ALU_OP_ADD]}}   & (alu_in1 + alu_in2);
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SUB]}}   & (alu_in1 - alu_in2);
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SLT]}}   & {{(XLEN-1){1'b0}}, slt};
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SLTU]}}  & {{(XLEN-1){1'b0}}, sltu};
    op_res |= {XLEN{alu_op_bus[`ALU_OP_XOR]}}   & (alu_in1 ^ alu_in2);
    op_res |= {XLEN{alu_op_bus[`ALU_OP_OR]}}    & (alu_in1 | alu_in2);
    op_res |= {XLEN{alu_op_bus[`ALU_OP_AND]}}   & (alu_in1 & alu_in2);
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SLL]}}   & sll_r;
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SRL]}}   & srl_r;
    op_res |= {XLEN{alu_op_bus[`ALU_OP_SRA]}}   & sra_r;
    op_res |= {XLEN{alu_op_bus[`ALU_OP_PASS2]}} & alu_in2;
    op_res |= {XLEN{alu_op_bus[`ALU_OP_EQ]}}    & {{(XLEN-1){1'b0}}, eq};
    op_res |= {XLEN{alu_op_bus[`ALU_OP_NE]}}    & {{(XLEN-1){1'b0}}, ~eq};
    op_res |= {XLEN{alu_op_bus[`ALU_OP_GE]}}    & {{(XLEN-1){1'b0}}, ~slt};
    op_res |= {XLEN{alu_op_bus[`ALU_OP_GEU]}}   & {{(XLEN-1){1'b0}}, ~sltu};
  end

  // Accept only when the result register is empty or being drained this cycle,
  // so a finished op (or serial shift) always has somewhere to land.
  assign alu_op_rdy = ~flush & (~res_vld_q | alu_res_rdy) & ~shift_busy;
  assign op_acc     = alu_op_vld & alu_op_rdy;
  assign pop        = res_vld_q & alu_res_rdy;

  always_comb begin
    res_vld_d = res_vld_q;
    res_d     = res_q;
    if (flush) begin
      res_vld_d = 1'b0;
    end else if (shift_done) begin
      res_vld_d = 1'b1;
      res_d     = shift_res;
    end else if (op_acc & ~long_shift) begin
      res_vld_d = 1'b1;
      res_d     = op_res;
    end else if (pop) begin
      // Value is kept; only valid drops.
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  assign alu_res_vld = res_vld_q;
  assign alu_res     = res_q;

endmodule

// File: tb/tb_lnrv_exu_alu.sv
// -----------------------------------------------------------------------------
// tb_lnrv_exu_alu
//   Self-checking bench for lnrv_exu_alu: directed cases, then randomized
//   one-hot ops with random result back-pressure and occasional flushes.
//   Expected results come from an arithmetic reference model and are queued
//   on accept; a monitor pops and compares on every result transfer.
// -----------------------------------------------------------------------------
module tb_lnrv_exu_alu;

  localparam int W    = 32;
  localparam int NOPS = 15;

  // Op bit positions
  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_XOR = 4,
                 OP_OR = 5, OP_AND = 6, OP_SLL = 7, OP_SRL = 8, OP_SRA = 9,
                 OP_PASS2 = 10, OP_EQ = 11, OP_NE = 12, OP_GE = 13, OP_GEU = 14;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic            alu_op_vld, alu_op_rdy;
  logic [NOPS-1:0] alu_op_bus;
  logic [W-1:0]    alu_in1, alu_in2;
  logic            alu_res_vld, alu_res_rdy;
  logic [W-1:0]    alu_res;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit rdy_rand = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lnrv_exu_alu dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alu_op_vld  (alu_op_vld),
    .alu_op_rdy  (alu_op_rdy),
    .alu_op_bus  (alu_op_bus),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_res_vld (alu_res_vld),
    .alu_res_rdy (alu_res_rdy),
    .alu_res     (alu_res)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_one(input int k, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint unsigned p;
    logic [63:0]     t;
    int              sa, sb;
    p  = 1;
    for (int i = 0; i < int'(b[4:0]); i++) p = p * 2;
    sa = int'(a);
    sb = int'(b);
    case (k)
      OP_ADD:   t = {32'b0, a} + {32'b0, b};
      OP_SUB:   t = {32'b0, a} + {32'b0, ~b} + 64'd1;
      OP_SLT:   t = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU:  t = (a < b) ? 64'd1 : 64'd0;
      OP_XOR:   t = {32'b0, a ^ b};
      OP_OR:    t = {32'b0, a | b};
      OP_AND:   t = {32'b0, a & b};
      OP_SLL:   t = {32'b0, a} * p;
      OP_SRL:   t = {32'b0, a} / p;
      // Floor division for negatives: floor(a/p) = ~(~a / p)
      OP_SRA:   t = a[31] ? ~({32'b0, ~a} / p) : {32'b0, a} / p;
      OP_PASS2: t = {32'b0, b};
      OP_EQ:    t = (a == b) ? 64'd1 : 64'd0;
      OP_NE:    t = (a != b) ? 64'd1 : 64'd0;
      OP_GE:    t = (sa >= sb) ? 64'd1 : 64'd0;
      OP_GEU:   t = (a >= b) ? 64'd1 : 64'd0;
      default:  t = 64'd0;
    endcase
    return t[31:0];
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [NOPS-1:0] bus,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = '0;
    for (int k = 0; k < NOPS; k++) if (bus[k]) r |= ref_one(k, a, b);
    return r;
  endfunction

  function automatic logic [NOPS-1:0] onehot(input int k);
    logic [NOPS-1:0] v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] pick_val();
    logic [W-1:0] corners[5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a request and hold it until accepted.
  task automatic issue(input logic [NOPS-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n = 0;
    alu_op_vld = 1'b1;
    alu_op_bus = op;
    alu_in1    = a;
    alu_in2    = b;
    #1;
    while (!alu_op_rdy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!alu_op_rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=op_rdy_low required=accept_within_100");
    end else begin
      exp_q.push_back(ref_alu(op, a, b));
    end
  endtask

  // Issue one op with res_rdy=1 and check its result one cycle later.
  task automatic issue_lat1(input string name, input logic [NOPS-1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp);
    @(negedge clk);
    alu_res_rdy = 1'b1;
    issue(op, a, b);
    @(negedge clk);
    alu_op_vld = 1'b0;
    #1;
    check({name, "_vld"}, {31'b0, alu_res_vld}, 32'd1);
    check(name, alu_res, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      alu_op_vld = 1'b0;
    end
  endtask

  // ---------------- back-pressure driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_rand) alu_res_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] held;
    bit holding;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || flush) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("hold_vld", {31'b0, alu_res_vld}, 32'd1);
          check("hold_res", alu_res, held);
        end
        holding = 1'b0;
        if (alu_res_vld && alu_res_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=no_result", alu_res);
          end else begin
            check("result", alu_res, exp_q.pop_front());
          end
        end else if (alu_res_vld) begin
          holding = 1'b1;
          held    = alu_res;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int           k;
    int           n;
    logic [NOPS-1:0] op;

    rst         = 1'b1;
    flush       = 1'b0;
    alu_op_vld  = 1'b0;
    alu_op_bus  = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_res_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_vld", {31'b0, alu_res_vld}, 32'd0);
    check("reset_res", alu_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_op_rdy", {31'b0, alu_op_rdy}, 32'd1);

    // Arithmetic wraps; compare ops signed/unsigned.
    issue_lat1("add_wrap", onehot(OP_ADD), 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue_lat1("slt_neg", onehot(OP_SLT), 32'hFFFF_FFFF, 32'd0, 32'd1);
    issue_lat1("sltu_big", onehot(OP_SLTU), 32'hFFFF_FFFF, 32'd0, 32'd0);
    issue_lat1("geu_equal", onehot(OP_GEU), 32'd5, 32'd5, 32'd1);
    issue_lat1("sra_barrel", onehot(OP_SRA), 32'h8000_0000, 32'd4, 32'hF800_0000);
    issue_lat1("zero_bus", '0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    issue_lat1("multi_hot", onehot(OP_ADD) | onehot(OP_XOR), 32'h0000_00F0,
               32'h0000_0011, 32'h0000_01E1);
    idle(2);

    // Back-pressure: XOR result held for 3 cycles, then pop + new OR.
    @(negedge clk);
    alu_res_rdy = 1'b0;
    issue(onehot(OP_XOR), 32'hFFFF_0000, 32'h5A5A_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_op_vld = 1'b0;
      #1;
      check("stall_res", alu_res, 32'hA5A5_0000);
      check("stall_op_rdy", {31'b0, alu_op_rdy}, 32'd0);
    end
    @(negedge clk);
    alu_res_rdy = 1'b1;
    issue(onehot(OP_OR), 32'h0F00_0000, 32'h0000_00F0);
    @(negedge clk);
    alu_op_vld = 1'b0;
    #1;
    check("b2b_vld", {31'b0, alu_res_vld}, 32'd1);
    check("b2b_res", alu_res, 32'h0F00_00F0);
    idle(2);

    // Flush with a held result and a pending request.
    @(negedge clk);
    alu_res_rdy = 1'b0;
    issue(onehot(OP_AND), 32'hFF00_FF00, 32'h0FF0_0FF0);
    @(negedge clk);
    alu_op_vld = 1'b0;
    @(negedge clk);
    flush      = 1'b1;
    alu_op_vld = 1'b1;
    alu_op_bus = onehot(OP_ADD);
    alu_in1    = 32'd7;
    alu_in2    = 32'd9;
    #1;
    check("flush_op_rdy", {31'b0, alu_op_rdy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    flush       = 1'b0;
    alu_op_vld  = 1'b0;
    alu_res_rdy = 1'b1;
    #1;
    check("flush_vld", {31'b0, alu_res_vld}, 32'd0);
    idle(1);

`ifdef LNRV_ALU_SERIAL_SHIFT_EN
    // Serial SRA by 4: busy 4 cycles, result on the 5th.
    @(negedge clk);
    alu_res_rdy = 1'b1;
    issue(onehot(OP_SRA), 32'h8000_0000, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      alu_op_vld = 1'b0;
      #1;
      check("serial_busy_rdy", {31'b0, alu_op_rdy}, 32'd0);
      check("serial_busy_vld", {31'b0, alu_res_vld}, 32'd0);
    end
    @(negedge clk);
    #1;
    check("serial_sra_vld", {31'b0, alu_res_vld}, 32'd1);
    check("serial_sra_res", alu_res, 32'hF800_0000);
    idle(1);
    issue_lat1("serial_sll0", onehot(OP_SLL), 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    idle(1);
    // Flush two cycles into a shamt=8 shift.
    @(negedge clk);
    issue(onehot(OP_SLL), 32'h0000_0001, 32'd8);
    @(negedge clk);
    alu_op_vld = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("serial_flush_rdy", {31'b0, alu_op_rdy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("serial_flush_novld", {31'b0, alu_res_vld}, 32'd0);
    end
`endif

    // Randomized traffic with random back-pressure and periodic flushes.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i % 60 == 59) begin
        flush      = 1'b1;
        alu_op_vld = 1'($urandom_range(0, 1));
        #1;
        check("rand_flush_op_rdy", {31'b0, alu_op_rdy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
      end
      k = $urandom_range(0, 15);
      op = (k == 15) ? '0 : onehot(k);
      issue(op, pick_val(), pick_val());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        alu_op_vld = 1'b0;
      end
    end

    // Drain everything still expected.
    @(negedge clk);
    alu_op_vld  = 1'b0;
    rdy_rand    = 1'b0;
    alu_res_rdy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
